// File: rtl/mul_pkg.sv
// mul_pkg: shared state encoding and sizing helpers for the iterative multiplier.
package mul_pkg;

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    localparam int WIDTH_DEF = 32;
    localparam int BPC_DEF   = 1;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul_iter_ctl.sv
// mul_iter_ctl: sequencer for mul_iter; flush cancels the operation and gates every strobe.
module mul_iter_ctl
    import mul_pkg::*;
#(
    parameter int N  = WIDTH_DEF / BPC_DEF,
    parameter int CW = cnt_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          flush,
    output logic          busy,
    output logic          done,
    output logic          load,
    output logic          step,
    output logic          write,
    output logic [CW-1:0] cnt
);

    state_t st, nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            st  <= IDLE;
            cnt <= '0;
        end else begin
            st  <= nxt;
            cnt <= load ? '0 : step ? cnt + 1'b1 : cnt;
        end
    end

    always_comb begin
        nxt   = st;
        load  = 1'b0;
        step  = 1'b0;
        write = 1'b0;
        unique case (st)
            IDLE: begin
                nxt  = start ? CALC : IDLE;
                load = start;
            end
            CALC: begin
                step = 1'b1;
                nxt  = (cnt == CW'(N - 1)) ? SIGN : CALC;
            end
            SIGN: begin
                write = 1'b1;
                nxt   = DONE;
            end
            DONE: begin
                nxt  = start ? CALC : IDLE;
                load = start;
            end
        endcase
        if (flush) begin
            nxt   = IDLE;
            load  = 1'b0;
            step  = 1'b0;
            write = 1'b0;
        end
    end

    assign busy = (st == CALC) || (st == SIGN);
    assign done = (st == DONE);

endmodule

// File: rtl/mul_iter.sv
// mul_iter: radix-2^BPC shift-add multiplier producing HI/LO for MULT/MULTU.
module mul_iter
    import mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int BPC   = BPC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int N  = WIDTH / BPC;
    localparam int CW = cnt_w(N);

    logic             load, step, write, neg;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand, mplr;
    logic [2*WIDTH-1:0] acc, part;

    mul_iter_ctl #(.N(N), .CW(CW)) u_ctl (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .flush(flush),
        .busy (busy),
        .done (done),
        .load (load),
        .step (step),
        .write(write),
        .cnt  (cnt)
    );

    // Operands are held as magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
    assign part = ((2*WIDTH)'(mcand) * (2*WIDTH)'(mplr[BPC-1:0])) << (cnt * BPC);

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand <= '0;
            mplr  <= '0;
            neg   <= 1'b0;
            acc   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            if (load) begin
                mcand <= (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
                mplr  <= (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
                neg   <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                acc   <= '0;
            end
            if (step) begin
                acc  <= acc + part;
                mplr <= mplr >> BPC;
            end
            if (write) {hi, lo} <= neg ? -acc : acc;
        end
    end

endmodule

// File: tb/tb_mul_iter.sv
// tb_mul_iter: scoreboard bench for mul_iter with BPC=1 and BPC=4 instances side by side.
module tb_mul_iter;

    typedef struct {
        logic [63:0] prod;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, start1, start4, sg, flush;
    logic [31:0] a, b;
    logic        busy1, done1, busy4, done4;
    logic [31:0] hi1, lo1, hi4, lo4;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          c0;
    exp_t        q1[$], q4[$];
    exp_t        e1, e4;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul_iter #(.WIDTH(32), .BPC(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .is_signed(sg), .op_a(a), .op_b(b),
        .flush(flush), .busy(busy1), .done(done1), .hi(hi1), .lo(lo1)
    );

    mul_iter #(.WIDTH(32), .BPC(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .is_signed(sg), .op_a(a), .op_b(b),
        .flush(flush), .busy(busy4), .done(done4), .hi(hi4), .lo(lo4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic [63:0] ex, ey;
        ex = s ? {{32{x[31]}}, x} : {32'b0, x};
        ey = s ? {{32{y[31]}}, y} : {32'b0, y};
        return ex * ey;
    endfunction

    always @(negedge clk) begin
        if (done1) begin
            if (q1.size() == 0) check("done1_spurious", 1, 0);
            else begin
                e1 = q1.pop_front();
                check("lat1", cyc, e1.due);
                check("prod1", {hi1, lo1}, e1.prod);
            end
        end
        if (done4) begin
            if (q4.size() == 0) check("done4_spurious", 1, 0);
            else begin
                e4 = q4.pop_front();
                check("lat4", cyc, e4.due);
                check("prod4", {hi4, lo4}, e4.prod);
            end
        end
    end

    task automatic go(input bit four, input logic [31:0] x, input logic [31:0] y, input logic s);
        @(negedge clk);
        a  = x;
        b  = y;
        sg = s;
        if (four) begin
            start4 = 1'b1;
            q4.push_back('{model(x, y, s), cyc + 10});
        end else begin
            start1 = 1'b1;
            q1.push_back('{model(x, y, s), cyc + 34});
        end
        @(negedge clk);
        start1 = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (q1.size() > 0 || q4.size() > 0); i++) @(negedge clk);
        check("drain", q1.size() + q4.size(), 0);
    endtask

    initial begin
        rst = 1'b1; start1 = 1'b0; start4 = 1'b0; flush = 1'b0; sg = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_hilo1", {hi1, lo1}, 64'h0);
        check("rst_hilo4", {hi4, lo4}, 64'h0);
        check("rst_flags", {busy1, done1, busy4, done4}, 64'h0);
        rst = 1'b0;

        @(negedge clk);
        a = 32'd3; b = 32'd5; sg = 1'b0; start1 = 1'b1;
        c0 = cyc;
        q1.push_back('{64'hF, c0 + 34});
        @(negedge clk);
        start1 = 1'b0;
        check("busy_first", busy1, 1);
        repeat (32) @(negedge clk);
        check("busy_last", {busy1, done1}, 64'h2);
        @(negedge clk);
        check("busy_off", busy1, 0);
        drain();
        check("small", {hi1, lo1}, 64'h00000000_0000000F);

        go(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0); drain();
        check("umax", {hi1, lo1}, 64'hFFFFFFFE_00000001);
        go(0, 32'hFFFFFFFF, 32'd2, 1'b1); drain();
        check("smixed", {hi1, lo1}, 64'hFFFFFFFF_FFFFFFFE);
        go(0, 32'h80000000, 32'h80000000, 1'b1); drain();
        check("scorner", {hi1, lo1}, 64'h40000000_00000000);

        // 7x6 gets a mid-run start (ignored) and is then flushed
        @(negedge clk);
        a = 32'd7; b = 32'd6; sg = 1'b0; start1 = 1'b1;
        c0 = cyc;
        q1.push_back('{64'd42, c0 + 34});
        @(negedge clk);
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        a = 32'd9; b = 32'd9; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        void'(q1.pop_back());
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle", {busy1, done1}, 64'h0);
        check("flush_hold", {hi1, lo1}, 64'h40000000_00000000);
        repeat (40) @(negedge clk);
        check("flush_hold2", {hi1, lo1}, 64'h40000000_00000000);
        go(0, 32'd9, 32'd9, 1'b0); drain();
        check("after_flush", {hi1, lo1}, 64'h51);

        // back-to-back on BPC=4: start held through the first DONE
        @(negedge clk);
        a = 32'd2; b = 32'd3; sg = 1'b0; start4 = 1'b1;
        c0 = cyc;
        q4.push_back('{64'd6, c0 + 10});
        q4.push_back('{64'd6, c0 + 20});
        repeat (11) @(negedge clk);
        start4 = 1'b0;
        drain();
        check("b2b", {hi4, lo4}, 64'd6);

        go(1, 32'h80000000, 32'h7FFFFFFF, 1'b1); drain();
        for (int i = 0; i < 6; i++) begin
            go(i[0], $urandom, $urandom, 1'($urandom_range(0, 1)));
            drain();
        end

        go(1, 32'd5, 32'd7, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_hilo4", {hi4, lo4}, 64'h0);
        check("rst_mid_hilo1", {hi1, lo1}, 64'h0);
        check("rst_mid_flags", {busy1, done1, busy4, done4}, 64'h0);
        q4.delete();
        rst = 1'b0;
        go(1, 32'd4, 32'd4, 1'b0); drain();
        check("recover", {hi4, lo4}, 64'd16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
